oflow_buffer_port_arbiter: RTL

//  Shares the single dual-line port of the MEM history buffer between the frame writer
//  (write-offset FSM, 2 lines/beat) and the similarity-metric reader (2 lines/beat).

---
 rtl/oflow_buffer_port_arbiter_if.sv | 79 +++++++
 rtl/oflow_buffer_port_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/oflow_buffer_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// oflow_buffer_port_arbiter_if
//   Bundles everything that connects the history-buffer port arbiter to its
//   neighbours: the frame-writer beat port, the similarity-reader beat port
//   and the single dual-line port of the MEM history buffer.
//
//   Modports
//     slave  : the arbiter's view (requests and buffer read data in;
//              grants, read return and buffer command out).
//     master : the environment's view (writer, reader and buffer together).
//
//   Signals
//     wr_req / wr_slot / wr_offset_0/1 / wr_data_0/1 : writer beat request
//     wr_gnt                                         : writer beat accepted
//     rd_req / rd_slot / rd_offset_0/1               : reader beat request
//     rd_gnt                                         : reader beat accepted
//     rd_valid / rd_data_0/1                         : read return
//     mem_en / mem_we / mem_addr_0/1 / mem_wdata_0/1 : buffer command
//     mem_rdata_0/1                                  : buffer read data
//     err_slot                                       : bad-slot pulse
// ---------------------------------------------------------------------------
interface oflow_buffer_port_arbiter_if #(
  parameter int SLOT_WIDTH   = 3,
  parameter int OFFSET_WIDTH = 6,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 128
);

  // Writer beat port
  logic                    wr_req;
  logic [SLOT_WIDTH-1:0]   wr_slot;
  logic [OFFSET_WIDTH-1:0] wr_offset_0;
  logic [OFFSET_WIDTH-1:0] wr_offset_1;
  logic [DATA_WIDTH-1:0]   wr_data_0;
  logic [DATA_WIDTH-1:0]   wr_data_1;
  logic                    wr_gnt;

  // Reader beat port
  logic                    rd_req;
  logic [SLOT_WIDTH-1:0]   rd_slot;
  logic [OFFSET_WIDTH-1:0] rd_offset_0;
  logic [OFFSET_WIDTH-1:0] rd_offset_1;
  logic                    rd_gnt;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data_0;
  logic [DATA_WIDTH-1:0]   rd_data_1;

  // Buffer port
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr_0;
  logic [ADDR_WIDTH-1:0]   mem_addr_1;
  logic [DATA_WIDTH-1:0]   mem_wdata_0;
  logic [DATA_WIDTH-1:0]   mem_wdata_1;
  logic [DATA_WIDTH-1:0]   mem_rdata_0;
  logic [DATA_WIDTH-1:0]   mem_rdata_1;

  // Status
  logic                    err_slot;

  modport slave (
    input  wr_req, wr_slot, wr_offset_0, wr_offset_1, wr_data_0, wr_data_1,
    input  rd_req, rd_slot, rd_offset_0, rd_offset_1,
    input  mem_rdata_0, mem_rdata_1,
    output wr_gnt, rd_gnt, rd_valid, rd_data_0, rd_data_1,
    output mem_en, mem_we, mem_addr_0, mem_addr_1, mem_wdata_0, mem_wdata_1,
    output err_slot
  );

  modport master (
    output wr_req, wr_slot, wr_offset_0, wr_offset_1, wr_data_0, wr_data_1,
    output rd_req, rd_slot, rd_offset_0, rd_offset_1,
    output mem_rdata_0, mem_rdata_1,
    input  wr_gnt, rd_gnt, rd_valid, rd_data_0, rd_data_1,
    input  mem_en, mem_we, mem_addr_0, mem_addr_1, mem_wdata_0, mem_wdata_1,
    input  err_slot
  );

endinterface

// File: rtl/oflow_buffer_port_arbiter.sv
// ---------------------------------------------------------------------------
// oflow_buffer_port_arbiter
//   Shares the single dual-line port of the MEM history buffer between the
//   frame writer and the similarity-metric reader, one beat (two lines) per
//   cycle. Round-robin with a burst cap: the current owner keeps the port
//   while it keeps requesting, unless the other side is waiting and the
//   owner has already had MAX_BURST consecutive beats. (slot, offset) pairs
//   are flattened to buffer addresses; read data returns one cycle after the
//   read grant together with rd_valid.
//
//   A request naming a slot >= NUM_SLOTS is still granted (so the requester
//   never stalls on it) but does not touch the buffer; err_slot pulses on
//   the following cycle instead.
//
//   Ports
//     clk     : clock
//     reset_N : asynchronous reset, active-low
//     bus     : oflow_buffer_port_arbiter_if.slave (writer, reader, buffer)
// ---------------------------------------------------------------------------
module oflow_buffer_port_arbiter #(
  parameter int NUM_SLOTS    = 5,
  parameter int SLOT_DEPTH   = 64,
  parameter int OFFSET_WIDTH = 6,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 128,
  parameter int MAX_BURST    = 8
) (
  input  logic                           clk,
  input  logic                           reset_N,
  oflow_buffer_port_arbiter_if.slave     bus
);

  localparam int SLOT_WIDTH = 3;
  localparam int CNT_WIDTH  = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_WR   = 2'd1,
    OWN_RD   = 2'd2
  } owner_e;

  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } side_e;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  // Extra leading bit keeps the compare correct even if NUM_SLOTS equals
  // 2**SLOT_WIDTH.
  function automatic logic slot_ok(input logic [SLOT_WIDTH-1:0] slot);
    return ({1'b0, slot} < (SLOT_WIDTH + 1)'(NUM_SLOTS));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] flat_addr(
    input logic [SLOT_WIDTH-1:0]   slot,
    input logic [OFFSET_WIDTH-1:0] offset
  );
    return ADDR_WIDTH'(slot) * ADDR_WIDTH'(SLOT_DEPTH) + ADDR_WIDTH'(offset);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  owner_e                 owner_q,      owner_d;
  side_e                  last_owner_q, last_owner_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q,   beat_cnt_d;
  logic                   rd_valid_q,   rd_valid_d;
  logic                   err_slot_q,   err_slot_d;

  logic                   grant_wr;
  logic                   grant_rd;
  logic                   burst_left;
  logic                   same_owner;
  logic                   wr_slot_ok;
  logic                   rd_slot_ok;

  logic [ADDR_WIDTH-1:0]  addr_0;
  logic [ADDR_WIDTH-1:0]  addr_1;
  logic [DATA_WIDTH-1:0]  wdata_0;
  logic [DATA_WIDTH-1:0]  wdata_1;

  assign burst_left = (beat_cnt_q < CNT_WIDTH'(MAX_BURST));
  assign wr_slot_ok = slot_ok(bus.wr_slot);
  assign rd_slot_ok = slot_ok(bus.rd_slot);

  // -------------------------------------------------------------------------
  // Arbitration: decided purely from registered state and this cycle's
  // requests, so the grants are combinational from req.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    unique case (owner_q)
      OWN_WR: begin
        if (bus.wr_req && (!bus.rd_req || burst_left)) grant_wr = 1'b1;
        else if (bus.rd_req)                           grant_rd = 1'b1;
      end
      OWN_RD: begin
        if (bus.rd_req && (!bus.wr_req || burst_left)) grant_rd = 1'b1;
        else if (bus.wr_req)                           grant_wr = 1'b1;
      end
      default: begin
        // Idle tie goes to whichever side did not have the last grant.
        if (bus.wr_req && bus.rd_req) begin
          if (last_owner_q == SIDE_RD) grant_wr = 1'b1;
          else                         grant_rd = 1'b1;
        end else begin
          grant_wr = bus.wr_req;
          grant_rd = bus.rd_req;
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  assign same_owner = (grant_wr && (owner_q == OWN_WR)) ||
                      (grant_rd && (owner_q == OWN_RD));

  always_comb begin
    owner_d      = OWN_IDLE;
    last_owner_d = last_owner_q;
    beat_cnt_d   = '0;

    if (grant_wr) begin
      owner_d      = OWN_WR;
      last_owner_d = SIDE_WR;
    end else if (grant_rd) begin
      owner_d      = OWN_RD;
      last_owner_d = SIDE_RD;
    end

    // Counter saturates at MAX_BURST: an owner running alone keeps the port
    // indefinitely, and the first waiting request then wins immediately.
    if (grant_wr || grant_rd) begin
      if (!same_owner)     beat_cnt_d = CNT_WIDTH'(1);
      else if (burst_left) beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      else                 beat_cnt_d = beat_cnt_q;
    end

    rd_valid_d = grant_rd && rd_slot_ok;
    err_slot_d = (grant_wr && !wr_slot_ok) || (grant_rd && !rd_slot_ok);
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      owner_q      <= OWN_IDLE;
      last_owner_q <= SIDE_RD;
      beat_cnt_q   <= '0;
      rd_valid_q   <= 1'b0;
      err_slot_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_valid_q   <= rd_valid_d;
      err_slot_q   <= err_slot_d;
    end
  end

  // -------------------------------------------------------------------------
  // Buffer command and read return
  // -------------------------------------------------------------------------
  always_comb begin
    addr_0  = '0;
    addr_1  = '0;
    wdata_0 = '0;
    wdata_1 = '0;
    if (grant_wr) begin
      addr_0  = flat_addr(bus.wr_slot, bus.wr_offset_0);
      addr_1  = flat_addr(bus.wr_slot, bus.wr_offset_1);
      wdata_0 = bus.wr_data_0;
      wdata_1 = bus.wr_data_1;
    end else if (grant_rd) begin
      addr_0  = flat_addr(bus.rd_slot, bus.rd_offset_0);
      addr_1  = flat_addr(bus.rd_slot, bus.rd_offset_1);
    end
  end

  assign bus.wr_gnt      = grant_wr;
  assign bus.rd_gnt      = grant_rd;
  assign bus.mem_en      = (grant_wr && wr_slot_ok) || (grant_rd && rd_slot_ok);
  assign bus.mem_we      = grant_wr;
  assign bus.mem_addr_0  = addr_0;
  assign bus.mem_addr_1  = addr_1;
  assign bus.mem_wdata_0 = wdata_0;
  assign bus.mem_wdata_1 = wdata_1;

  // Buffer has one-cycle read latency, so its output lines up with rd_valid.
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data_0   = rd_valid_q ? bus.mem_rdata_0 : '0;
  assign bus.rd_data_1   = rd_valid_q ? bus.mem_rdata_1 : '0;
  assign bus.err_slot    = err_slot_q;

endmodule
